dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Shares the single dmem port between the processor data path and a debug/loader requester.
- The processor has default priority. The debug port gets a bounded-starvation guarantee and an optional locked burst mode.
- When the processor loses arbitration, it is stalled with p_stall, and it freezes PC and register writes for that cycle.
- Sits between the processor's dmem signals (addr_to_mem, write_enable_to_mem, byte/half/sign controls) and dmem.

Parameters:
- ADDR_W, 32, address width; vectors use [0:W-1] ordering like the rest of the core.
- DATA_W, 32, data width.
- MAX_WAIT, 4, consecutive cycles a pending debug request may be denied before it is forced through; 0 gives debug strict priority.
- CNT_W, 16, width of the statistics counters (optional feature only).

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- p_req  in  1  processor requests a memory access this cycle.
- p_we, p_byte, p_half, p_sext  in  1 each  processor write-enable, byte, half-word and sign-extend controls.
- p_addr  in  ADDR_W  processor address.
- p_wdata  in  DATA_W  processor store data.
- p_rdata  out  DATA_W  load data to the processor.
- p_stall  out  1  processor access denied this cycle.
- d_req  in  1  debug requests an access.
- d_lock  in  1  hold debug ownership after this grant.
- d_we, d_byte, d_half, d_sext  in  1 each  debug access controls.
- d_addr  in  ADDR_W  debug address.
- d_wdata  in  DATA_W  debug store data.
- d_rdata  out  DATA_W  load data to debug.
- d_gnt  out  1  debug access performed this cycle.
- mem_addr  out  ADDR_W  to dmem addr.
- mem_we, mem_byte, mem_half, mem_sext  out  1 each  to dmem.
- mem_wdata  out  DATA_W  to dmem data_in.
- mem_rdata  in  DATA_W  from dmem data_out.

Behaviour:
- State register has two states: S_SHARED and S_DBG_LOCK. There is also wait_cnt, a saturating counter of 0..MAX_WAIT.
- Grant is combinational within the same cycle, because dmem reads combinationally and writes on the edge. There is zero added latency.
- Grant rules in S_SHARED:
  - d_gnt = d_req & (!p_req | wait_cnt==MAX_WAIT).
  - Otherwise the processor is granted if p_req.
- Grant rules in S_DBG_LOCK:
  - d_gnt = d_req.
  - The processor is never granted.
- p_stall = p_req & !p_gnt.
- Mux: mem_* carry the granted requester's fields. With no grant, mem_we=0 and the other mem_* outputs are 0.
- p_rdata and d_rdata both carry mem_rdata. Each is valid only for the granted side.
- wait_cnt update at each edge:
  - Clear if d_gnt or !d_req.
  - Else increment, saturating at MAX_WAIT.
- State transitions:
  - S_SHARED -> S_DBG_LOCK when d_gnt & d_lock.
  - S_DBG_LOCK -> S_SHARED at any edge where d_lock==0 or d_req==0.
  - A request dropped mid-lock releases the lock.
- Simultaneous requests with wait_cnt<MAX_WAIT: the processor wins and the debug access waits.
- With MAX_WAIT=0, debug always wins on a collision.
- Reset:
  - State S_SHARED, wait_cnt=0.
  - While reset is high: d_gnt=0, p_stall=0, mem_we=0, mem_addr=0.
  - Reset asserted mid-lock returns to S_SHARED on the next edge.

Optional Feature:
- Macro: DMEM_ARB_STATS_EN.
- With the macro defined:
  - Adds outputs stat_stall_cycles[CNT_W] and stat_dbg_grants[CNT_W].
  - stat_stall_cycles counts cycles with p_stall=1; stat_dbg_grants counts cycles with d_gnt=1.
  - Both are saturating at all-ones and cleared by reset.
- Without the macro: the ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Package dmem_arb_pkg holds:
  - the state encoding (S_SHARED=1'b0, S_DBG_LOCK=1'b1);
  - default ADDR_W/DATA_W constants;
  - the access-control bundle field order.
- One natural sub-module is sat_counter (parameterised width/max, with inc and clr inputs). It is used for wait_cnt and for both statistics counters.

Test Plan:
- Processor only: p_req=1, p_we=1, p_addr=0x100, p_wdata=0xDEADBEEF, d_req=0 -> mem_we=1, mem_addr=0x100, p_stall=0, and dmem word 0x100 reads back 0xDEADBEEF.
- Collision with MAX_WAIT=4: p_req and d_req held high continuously -> processor granted for cycles 1-4 (wait_cnt 0..3→4), d_gnt=1 with p_stall=1 in cycle 5, and the pattern repeats every 5 cycles.
- Idle processor: p_req=0, d_req=1, d_addr=0x20 load -> d_gnt=1 the same cycle and d_rdata equals dmem content at 0x20.
- Locked burst: d_req=1, d_lock=1 for 3 cycles with addresses 0x0/0x4/0x8, then d_lock=0, while p_req=1 throughout -> p_stall=1 for all 3 locked cycles, and the processor is granted the cycle after release.
- Reset mid-lock: assert reset for 1 cycle during S_DBG_LOCK -> mem_we=0 during reset, then state S_SHARED, and a p_req collision next cycle goes to the processor.
- DMEM_ARB_STATS_EN: run the collision scenario for 10 cycles -> stat_dbg_grants=2 and stat_stall_cycles=2; after reset both read 0.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// rtl/dmem_arb_pkg.sv - shared types and constants for the dmem arbiter
package dmem_arb_pkg;

  // Arbiter ownership state: shared by priority, or held by a locked debug burst
  typedef enum logic {
    S_SHARED   = 1'b0,
    S_DBG_LOCK = 1'b1
  } arb_state_t;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;

  // Access-control bundle, field order: write-enable, byte, half-word, sign-extend
  typedef struct packed {
    logic we;
    logic byte_sel;
    logic half;
    logic sext;
  } acc_ctl_t;

  localparam acc_ctl_t ACC_CTL_IDLE = '{we: 1'b0, byte_sel: 1'b0, half: 1'b0, sext: 1'b0};

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous clear
module sat_counter #(
  parameter int         W   = 4,
  parameter logic [W-1:0] MAX = '1
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  // Count up on inc, hold at MAX, clear wins over increment
  always_ff @(posedge clock) begin
    if (reset || clr) begin
      count <= '0;
    end else if (inc && (count != MAX)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - dmem port arbiter between processor and debug (optional stats: DMEM_ARB_STATS_EN)
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int MAX_WAIT = 4
`ifdef DMEM_ARB_STATS_EN
  ,
  parameter int CNT_W    = 16
`endif
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              p_req,
  input  logic              p_we,
  input  logic              p_byte,
  input  logic              p_half,
  input  logic              p_sext,
  input  logic [0:ADDR_W-1] p_addr,
  input  logic [0:DATA_W-1] p_wdata,
  output logic [0:DATA_W-1] p_rdata,
  output logic              p_stall,
  input  logic              d_req,
  input  logic              d_lock,
  input  logic              d_we,
  input  logic              d_byte,
  input  logic              d_half,
  input  logic              d_sext,
  input  logic [0:ADDR_W-1] d_addr,
  input  logic [0:DATA_W-1] d_wdata,
  output logic [0:DATA_W-1] d_rdata,
  output logic              d_gnt,
  output logic [0:ADDR_W-1] mem_addr,
  output logic              mem_we,
  output logic              mem_byte,
  output logic              mem_half,
  output logic              mem_sext,
  output logic [0:DATA_W-1] mem_wdata,
  input  logic [0:DATA_W-1] mem_rdata
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [CNT_W-1:0]  stat_stall_cycles,
  output logic [CNT_W-1:0]  stat_dbg_grants
`endif
);

  // A zero MAX_WAIT still needs a one-bit counter; it simply never leaves zero
  localparam int WAIT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

  arb_state_t        state;
  arb_state_t        state_nx;
  logic              p_gnt;
  logic              wait_at_max;
  logic [WAIT_W-1:0] wait_cnt;
  acc_ctl_t          p_ctl;
  acc_ctl_t          d_ctl;
  acc_ctl_t          mem_ctl;

  assign p_ctl = '{we: p_we, byte_sel: p_byte, half: p_half, sext: p_sext};
  assign d_ctl = '{we: d_we, byte_sel: d_byte, half: d_half, sext: d_sext};

  assign wait_at_max = (wait_cnt == WAIT_MAX);

  // Starvation counter: how long the current debug request has been refused
  sat_counter #(
    .W   (WAIT_W),
    .MAX (WAIT_MAX)
  ) u_wait_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (1'b1),
    .clr   (d_gnt | ~d_req),
    .count (wait_cnt)
  );

  // Ownership state register
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= S_SHARED;
    end else begin
      state <= state_nx;
    end
  end

  // Same-cycle grant decision and lock entry/exit; reset suppresses every grant
  always_comb begin
    state_nx = state;
    d_gnt    = 1'b0;
    p_gnt    = 1'b0;
    case (state)
      S_SHARED: begin
        d_gnt = d_req & (~p_req | wait_at_max);
        p_gnt = p_req & ~d_gnt;
        if (d_gnt && d_lock) begin
          state_nx = S_DBG_LOCK;
        end
      end
      S_DBG_LOCK: begin
        d_gnt = d_req;
        p_gnt = 1'b0;
        if (!d_lock || !d_req) begin
          state_nx = S_SHARED;
        end
      end
      default: begin
        state_nx = S_SHARED;
      end
    endcase
    if (reset) begin
      d_gnt    = 1'b0;
      p_gnt    = 1'b0;
      state_nx = S_SHARED;
    end
  end

  assign p_stall = p_req & ~p_gnt & ~reset;

  // Route the granted requester onto dmem; an idle port drives all zeros
  always_comb begin
    mem_ctl   = ACC_CTL_IDLE;
    mem_addr  = '0;
    mem_wdata = '0;
    if (d_gnt) begin
      mem_ctl   = d_ctl;
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
    end else if (p_gnt) begin
      mem_ctl   = p_ctl;
      mem_addr  = p_addr;
      mem_wdata = p_wdata;
    end
  end

  assign mem_we   = mem_ctl.we;
  assign mem_byte = mem_ctl.byte_sel;
  assign mem_half = mem_ctl.half;
  assign mem_sext = mem_ctl.sext;

  // Read data is broadcast; only the granted side treats it as valid
  assign p_rdata = mem_rdata;
  assign d_rdata = mem_rdata;

`ifdef DMEM_ARB_STATS_EN
  sat_counter #(
    .W   (CNT_W),
    .MAX ({CNT_W{1'b1}})
  ) u_stat_stall (
    .clock (clock),
    .reset (reset),
    .inc   (p_stall),
    .clr   (1'b0),
    .count (stat_stall_cycles)
  );

  sat_counter #(
    .W   (CNT_W),
    .MAX ({CNT_W{1'b1}})
  ) u_stat_dbg (
    .clock (clock),
    .reset (reset),
    .inc   (d_gnt),
    .clr   (1'b0),
    .count (stat_dbg_grants)
  );
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - table-driven checks for dmem_arbiter (stats checks with DMEM_ARB_STATS_EN)
module tb_dmem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic          reset;
  logic          p_req, p_we, p_byte, p_half, p_sext;
  logic [0:AW-1] p_addr;
  logic [0:DW-1] p_wdata, p_rdata;
  logic          p_stall;
  logic          d_req, d_lock, d_we, d_byte, d_half, d_sext;
  logic [0:AW-1] d_addr;
  logic [0:DW-1] d_wdata, d_rdata;
  logic          d_gnt;
  logic [0:AW-1] mem_addr;
  logic          mem_we, mem_byte, mem_half, mem_sext;
  logic [0:DW-1] mem_wdata, mem_rdata;
`ifdef DMEM_ARB_STATS_EN
  logic [15:0]   stat_stall_cycles, stat_dbg_grants;
`endif

  dmem_arbiter dut (
    .clock(clock), .reset(reset),
    .p_req(p_req), .p_we(p_we), .p_byte(p_byte), .p_half(p_half), .p_sext(p_sext),
    .p_addr(p_addr), .p_wdata(p_wdata), .p_rdata(p_rdata), .p_stall(p_stall),
    .d_req(d_req), .d_lock(d_lock), .d_we(d_we), .d_byte(d_byte), .d_half(d_half),
    .d_sext(d_sext), .d_addr(d_addr), .d_wdata(d_wdata), .d_rdata(d_rdata), .d_gnt(d_gnt),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_byte(mem_byte), .mem_half(mem_half),
    .mem_sext(mem_sext), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
`ifdef DMEM_ARB_STATS_EN
    , .stat_stall_cycles(stat_stall_cycles), .stat_dbg_grants(stat_dbg_grants)
`endif
  );

  // Word-addressed dmem model: combinational read, write on the edge
  logic [31:0] mem [0:255];
  logic [31:0] addr_flat;
  assign addr_flat = mem_addr;
  always_comb mem_rdata = mem[addr_flat[9:2]];
  always @(posedge clock) if (mem_we) mem[addr_flat[9:2]] <= mem_wdata;

  typedef struct {
    logic        p_req, p_we;
    logic [2:0]  p_bhs;
    logic [31:0] p_addr, p_wdata;
    logic        d_req, d_lock, d_we;
    logic [2:0]  d_bhs;
    logic [31:0] d_addr, d_wdata;
    logic        e_stall, e_gnt, e_we;
    logic [2:0]  e_bhs;
    logic [31:0] e_addr, e_wdata;
    logic        chk_rd;
    logic [31:0] e_rdata;
  } vec_t;

  vec_t tbl[$];
  int checks = 0;
  int errors = 0;

  function automatic vec_t mk(
    logic pr, logic pw, logic [2:0] pb, logic [31:0] pa, logic [31:0] pd,
    logic dr, logic dl, logic dw, logic [2:0] db, logic [31:0] da, logic [31:0] dd,
    logic es, logic eg, logic ew, logic [2:0] eb, logic [31:0] ea, logic [31:0] ed,
    logic cr, logic [31:0] er);
    vec_t v;
    v.p_req = pr; v.p_we = pw; v.p_bhs = pb; v.p_addr = pa; v.p_wdata = pd;
    v.d_req = dr; v.d_lock = dl; v.d_we = dw; v.d_bhs = db; v.d_addr = da; v.d_wdata = dd;
    v.e_stall = es; v.e_gnt = eg; v.e_we = ew; v.e_bhs = eb; v.e_addr = ea; v.e_wdata = ed;
    v.chk_rd = cr; v.e_rdata = er;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    p_req = v.p_req; p_we = v.p_we; {p_byte, p_half, p_sext} = v.p_bhs;
    p_addr = v.p_addr; p_wdata = v.p_wdata;
    d_req = v.d_req; d_lock = v.d_lock; d_we = v.d_we; {d_byte, d_half, d_sext} = v.d_bhs;
    d_addr = v.d_addr; d_wdata = v.d_wdata;
  endtask

  task automatic idle();
    apply(mk(0,0,3'b000,32'h0,32'h0, 0,0,0,3'b000,32'h0,32'h0, 0,0,0,3'b000,32'h0,32'h0, 0,32'h0));
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    vec_t pc, dc;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[8] = 32'h12345678;

    // Table: processor store/load, idle-processor debug load, collisions, locked burst
    tbl.push_back(mk(1,1,3'b100,32'h100,32'hDEADBEEF, 0,0,0,3'b000,32'h0,32'h0,
                     0,0,1,3'b100,32'h100,32'hDEADBEEF, 0,32'h0));
    tbl.push_back(mk(1,0,3'b000,32'h100,32'h0, 0,0,0,3'b000,32'h0,32'h0,
                     0,0,0,3'b000,32'h100,32'h0, 1,32'hDEADBEEF));
    tbl.push_back(mk(0,0,3'b000,32'h0,32'h0, 1,0,0,3'b011,32'h20,32'h0,
                     0,1,0,3'b011,32'h20,32'h0, 1,32'h12345678));
    pc = mk(1,0,3'b010,32'h40,32'h0, 1,0,1,3'b101,32'h44,32'hA5A5A5A5,
            0,0,0,3'b010,32'h40,32'h0, 0,32'h0);
    dc = mk(1,0,3'b010,32'h40,32'h0, 1,0,1,3'b101,32'h44,32'hA5A5A5A5,
            1,1,1,3'b101,32'h44,32'hA5A5A5A5, 0,32'h0);
    for (int i = 0; i < 10; i++) tbl.push_back((i % 5 == 4) ? dc : pc);
    tbl.push_back(mk(1,0,3'b000,32'h44,32'h0, 0,0,0,3'b000,32'h0,32'h0,
                     0,0,0,3'b000,32'h44,32'h0, 1,32'hA5A5A5A5));
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk(1,0,3'b000,32'h40,32'h0, 1,1,1,3'b000,32'h0,32'h11,
                       0,0,0,3'b000,32'h40,32'h0, 0,32'h0));
    tbl.push_back(mk(1,0,3'b000,32'h40,32'h0, 1,1,1,3'b000,32'h0,32'h11,
                     1,1,1,3'b000,32'h0,32'h11, 0,32'h0));
    tbl.push_back(mk(1,0,3'b000,32'h40,32'h0, 1,1,1,3'b000,32'h4,32'h22,
                     1,1,1,3'b000,32'h4,32'h22, 0,32'h0));
    tbl.push_back(mk(1,0,3'b000,32'h40,32'h0, 1,0,1,3'b000,32'h8,32'h33,
                     1,1,1,3'b000,32'h8,32'h33, 0,32'h0));
    tbl.push_back(mk(1,0,3'b000,32'h4,32'h0, 0,0,0,3'b000,32'h0,32'h0,
                     0,0,0,3'b000,32'h4,32'h0, 1,32'h22));
    tbl.push_back(mk(0,1,3'b111,32'h300,32'h55, 0,0,1,3'b111,32'h304,32'h66,
                     0,0,0,3'b000,32'h0,32'h0, 0,32'h0));

    // Reset state: both requesting, nothing may reach dmem
    reset = 1'b1;
    idle();
    p_req = 1'b1; p_we = 1'b1; p_addr = 32'h100;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h200;
    #2;
    chk("reset_d_gnt", {31'b0, d_gnt}, 32'h0);
    chk("reset_p_stall", {31'b0, p_stall}, 32'h0);
    chk("reset_mem_we", {31'b0, mem_we}, 32'h0);
    chk("reset_mem_addr", mem_addr, 32'h0);
    step();
    step();
    reset = 1'b0;
    idle();

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i]);
      #2;
      chk($sformatf("row%0d_p_stall", i), {31'b0, p_stall}, {31'b0, tbl[i].e_stall});
      chk($sformatf("row%0d_d_gnt", i), {31'b0, d_gnt}, {31'b0, tbl[i].e_gnt});
      chk($sformatf("row%0d_mem_we", i), {31'b0, mem_we}, {31'b0, tbl[i].e_we});
      chk($sformatf("row%0d_mem_bhs", i), {29'b0, mem_byte, mem_half, mem_sext}, {29'b0, tbl[i].e_bhs});
      chk($sformatf("row%0d_mem_addr", i), mem_addr, tbl[i].e_addr);
      chk($sformatf("row%0d_mem_wdata", i), mem_wdata, tbl[i].e_wdata);
      if (tbl[i].chk_rd) begin
        if (tbl[i].e_gnt) chk($sformatf("row%0d_d_rdata", i), d_rdata, tbl[i].e_rdata);
        else              chk($sformatf("row%0d_p_rdata", i), p_rdata, tbl[i].e_rdata);
      end
      step();
    end

    // Reset asserted while locked must drop back to shared priority
    idle();
    d_req = 1'b1; d_lock = 1'b1; d_we = 1'b1; d_addr = 32'h50; d_wdata = 32'h77;
    #2;
    chk("lock_enter_d_gnt", {31'b0, d_gnt}, 32'h1);
    step();
    p_req = 1'b1; p_addr = 32'h60;
    #2;
    chk("lock_hold_d_gnt", {31'b0, d_gnt}, 32'h1);
    chk("lock_hold_p_stall", {31'b0, p_stall}, 32'h1);
    step();
    reset = 1'b1;
    #2;
    chk("lock_reset_mem_we", {31'b0, mem_we}, 32'h0);
    chk("lock_reset_d_gnt", {31'b0, d_gnt}, 32'h0);
    chk("lock_reset_p_stall", {31'b0, p_stall}, 32'h0);
    chk("lock_reset_mem_addr", mem_addr, 32'h0);
    step();
    reset = 1'b0;
    #2;
    chk("after_reset_p_stall", {31'b0, p_stall}, 32'h0);
    chk("after_reset_d_gnt", {31'b0, d_gnt}, 32'h0);
    chk("after_reset_mem_addr", mem_addr, 32'h60);
    step();

`ifdef DMEM_ARB_STATS_EN
    // Ten collision cycles from a clean reset: two debug grants, two stalls
    reset = 1'b1;
    idle();
    step();
    reset = 1'b0;
    apply(pc);
    for (int i = 0; i < 10; i++) step();
    idle();
    #2;
    chk("stat_dbg_grants", {16'b0, stat_dbg_grants}, 32'd2);
    chk("stat_stall_cycles", {16'b0, stat_stall_cycles}, 32'd2);
    reset = 1'b1;
    step();
    reset = 1'b0;
    #2;
    chk("stat_dbg_grants_reset", {16'b0, stat_dbg_grants}, 32'd0);
    chk("stat_stall_cycles_reset", {16'b0, stat_stall_cycles}, 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
